mc_main_control: RTL
====================

# mc_main_control

Multi-cycle main control FSM for the MIPS datapath. Each cycle it decodes the latched instruction opcode and issues the datapath strobes, including the 2-bit ALU_OP consumed by the ALU control decoder. Memory accesses wait on a ready handshake. The block sits between the instruction register and the shared ALU/memory/register-file datapath, and sequences every instruction through fetch, decode, execute, memory and writeback.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  6  opcode field of the instruction register
- Mem_Ready  in  1  memory handshake; access completes in any cycle where it is 1
- PC_Write  out  1  unconditional PC load
- PC_Write_Cond  out  1  PC load qualified by ALU Zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- Mem_Read  out  1  memory read strobe
- Mem_Write  out  1  memory write strobe
- IR_Write  out  1  instruction register load
- Mem_To_Reg  out  1  write-data select: 0 = ALUOut, 1 = MDR
- Reg_Dst  out  1  destination select: 0 = rt, 1 = rd
- Reg_Write  out  1  register-file write enable
- ALU_SrcA  out  1  0 = PC, 1 = A register
- ALU_SrcB  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALU_OP  out  2  00 = add, 01 = subtract, 10 = R-type (funct decides)
- PC_Source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- Instr_Done  out  1  one-cycle pulse in the final cycle of each instruction
- Illegal  out  1  sticky flag for an unsupported opcode
- State  out  4  current state encoding, for debug

## Operation
- States and encodings:
  - RST = 0, IF = 1, ID = 2, MADDR = 3, MRD = 4, MWB = 5, MWR = 6
  - REX = 7, RWB = 8, BEQ = 9, JMP = 10, IEX = 11, IWB = 12, ILL = 15
- Opcodes: R-type = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000.
- Transitions:
  - RST -> IF, unconditionally.
  - IF -> ID when Mem_Ready = 1; otherwise IF is held.
  - ID branches on Op:
    - R-type -> REX
    - lw or sw -> MADDR
    - beq -> BEQ
    - j -> JMP
    - addi -> IEX
    - any other opcode -> ILL
  - MADDR -> MRD (lw) or MWR (sw).
  - MRD -> MWB when Mem_Ready = 1.
  - MWR -> IF when Mem_Ready = 1.
  - REX -> RWB; IEX -> IWB.
  - MWB, RWB, IWB, BEQ and JMP all -> IF.
  - ILL holds until reset.
- Outputs are 0 unless listed below.
  - IF: Mem_Read = 1, ALU_SrcB = 01, ALU_OP = 00. IR_Write and PC_Write equal Mem_Ready (Mealy qualification).
  - ID: ALU_SrcB = 11, ALU_OP = 00 (branch target precompute).
  - MADDR and IEX: ALU_SrcA = 1, ALU_SrcB = 10, ALU_OP = 00.
  - MRD: Mem_Read = 1, IorD = 1.
  - MWR: Mem_Write = 1, IorD = 1.
  - MWB: Reg_Write = 1, Mem_To_Reg = 1.
  - REX: ALU_SrcA = 1, ALU_SrcB = 00, ALU_OP = 10.
  - RWB: Reg_Write = 1, Reg_Dst = 1.
  - IWB: Reg_Write = 1, Reg_Dst = 0, Mem_To_Reg = 0.
  - BEQ: ALU_SrcA = 1, ALU_OP = 01, PC_Write_Cond = 1, PC_Source = 01.
  - JMP: PC_Write = 1, PC_Source = 10.
- Instr_Done = 1 in each of these cycles: MWB; MWR with Mem_Ready = 1; RWB; IWB; BEQ; JMP.
- Illegal is set on entry to ILL. In ILL, every strobe is 0.
- Op is sampled only in ID and MADDR. Op changes in any other state have no effect.

## Timing
- Reset (rst_n = 0): State = RST, Illegal = 0, and every output is 0 immediately, with no clock edge needed.
- The first rising edge after release enters IF.
- Latency in cycles from IF entry to Instr_Done, with zero-wait memory:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4
- Each cycle where Mem_Ready = 0 in IF, MRD or MWR adds one cycle to that latency.
- The strobe of a waiting state stays asserted and stable until the completing cycle.
- Mem_Ready is ignored in all other states.
- If rst_n falls during a memory wait, the state returns to RST at once and every strobe drops asynchronously.
- State register and Illegal are flops. All other outputs are combinational from State, plus Mem_Ready in IF/MWR.

## Configuration
- MC_ADDI_EN defined: the addi opcode is decoded to IEX/IWB as described.
- MC_ADDI_EN undefined:
  - IEX and IWB are not built.
  - Opcode 001000 is illegal: ID -> ILL and Illegal = 1.

## Test plan
- Reset with rst_n = 0 mid-IF -> all outputs 0, State = 0. Release -> State = 1 on the next edge, with Mem_Read = 1.
- Op = 000000, Mem_Ready = 1 -> states 1, 2, 7, 8. ALU_OP = 10 in REX. Reg_Write = 1 and Reg_Dst = 1 in RWB. Instr_Done in cycle 4.
- Op = 100011, Mem_Ready low for 2 cycles in MRD -> Mem_Read and IorD held 3 cycles. MWB asserts Reg_Write and Mem_To_Reg. Total 7 cycles.
- Op = 000100 then 000010 -> BEQ: ALU_OP = 01, PC_Write_Cond = 1, PC_Source = 01. JMP: PC_Write = 1, PC_Source = 10. 3 cycles each.
- Op = 111111 -> ILL: Illegal = 1 sticky, all strobes 0. rst_n pulse clears it.
- Op = 001000 -> with MC_ADDI_EN: IEX/IWB, Reg_Write = 1, Reg_Dst = 0, 4 cycles. Without the macro: Illegal = 1.

Source files
------------

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/mem/writeback sequencing.
// Optional macro MC_ADDI_EN builds the addi path (IEX/IWB); otherwise addi is illegal.
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       PC_Write_Cond,
  output logic       IorD,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       Mem_To_Reg,
  output logic       Reg_Dst,
  output logic       Reg_Write,
  output logic       ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic [1:0] ALU_OP,
  output logic [1:0] PC_Source,
  output logic       Instr_Done,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_IF    = 4'd1,
    S_ID    = 4'd2,
    S_MADDR = 4'd3,
    S_MRD   = 4'd4,
    S_MWB   = 4'd5,
    S_MWR   = 4'd6,
    S_REX   = 4'd7,
    S_RWB   = 4'd8,
    S_BEQ   = 4'd9,
    S_JMP   = 4'd10,
    S_IEX   = 4'd11,
    S_IWB   = 4'd12,
    S_ILL   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state;
  state_t nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_RST:   nxt = S_IF;
      S_IF:    nxt = Mem_Ready ? S_ID : S_IF;
      S_ID: begin
        case (Op)
          OP_R:    nxt = S_REX;
          OP_LW:   nxt = S_MADDR;
          OP_SW:   nxt = S_MADDR;
          OP_BEQ:  nxt = S_BEQ;
          OP_J:    nxt = S_JMP;
`ifdef MC_ADDI_EN
          OP_ADDI: nxt = S_IEX;
`endif
          default: nxt = S_ILL;
        endcase
      end
      S_MADDR: nxt = (Op == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   nxt = Mem_Ready ? S_MWB : S_MRD;
      S_MWR:   nxt = Mem_Ready ? S_IF : S_MWR;
      S_MWB:   nxt = S_IF;
      S_REX:   nxt = S_RWB;
      S_RWB:   nxt = S_IF;
      S_BEQ:   nxt = S_IF;
      S_JMP:   nxt = S_IF;
`ifdef MC_ADDI_EN
      S_IEX:   nxt = S_IWB;
      S_IWB:   nxt = S_IF;
`endif
      S_ILL:   nxt = S_ILL;
      default: nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RST;
      Illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == S_ILL) Illegal <= 1'b1;
    end
  end

  assign State = state;

  always_comb begin
    PC_Write      = 1'b0;
    PC_Write_Cond = 1'b0;
    IorD          = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Write     = 1'b0;
    IR_Write      = 1'b0;
    Mem_To_Reg    = 1'b0;
    Reg_Dst       = 1'b0;
    Reg_Write     = 1'b0;
    ALU_SrcA      = 1'b0;
    ALU_SrcB      = 2'b00;
    ALU_OP        = 2'b00;
    PC_Source     = 2'b00;
    Instr_Done    = 1'b0;
    case (state)
      S_IF: begin
        Mem_Read = 1'b1;
        ALU_SrcB = 2'b01;
        IR_Write = Mem_Ready;
        PC_Write = Mem_Ready;
      end
      S_ID:    ALU_SrcB = 2'b11;
      S_MADDR: begin
        ALU_SrcA = 1'b1;
        ALU_SrcB = 2'b10;
      end
      S_MRD: begin
        Mem_Read = 1'b1;
        IorD     = 1'b1;
      end
      S_MWR: begin
        Mem_Write  = 1'b1;
        IorD       = 1'b1;
        Instr_Done = Mem_Ready;
      end
      S_MWB: begin
        Reg_Write  = 1'b1;
        Mem_To_Reg = 1'b1;
        Instr_Done = 1'b1;
      end
      S_REX: begin
        ALU_SrcA = 1'b1;
        ALU_OP   = 2'b10;
      end
      S_RWB: begin
        Reg_Write  = 1'b1;
        Reg_Dst    = 1'b1;
        Instr_Done = 1'b1;
      end
      S_BEQ: begin
        ALU_SrcA      = 1'b1;
        ALU_OP        = 2'b01;
        PC_Write_Cond = 1'b1;
        PC_Source     = 2'b01;
        Instr_Done    = 1'b1;
      end
      S_JMP: begin
        PC_Write   = 1'b1;
        PC_Source  = 2'b10;
        Instr_Done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_IEX: begin
        ALU_SrcA = 1'b1;
        ALU_SrcB = 2'b10;
      end
      S_IWB: begin
        Reg_Write  = 1'b1;
        Instr_Done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
